mux4x1_collector: RTL and testbench



---
 rtl/mux4x1_collector.sv | 154 +++++++++++++++
 tb/tb_mux4x1_collector.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux4x1_collector.sv
// Four-lane to one-lane valid/ready collector with round-robin arbitration and a
// registered, lane-tagged output. Optional macro MUX4_TOGGLE_CNT_EN adds toggle_cnt.
module mux4x1_collector #(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    in_valid,
  input  logic [DW-1:0] in_data0,
  input  logic [DW-1:0] in_data1,
  input  logic [DW-1:0] in_data2,
  input  logic [DW-1:0] in_data3,
  output logic [3:0]    in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic [1:0]    out_sel,
  input  logic          out_ready
`ifdef MUX4_TOGGLE_CNT_EN
  ,
  output logic [15:0]   toggle_cnt
`endif
);

  // First valid lane after 'last' in circular order; 'last' itself is checked last.
  function automatic logic [1:0] rr_grant_f(input logic [3:0] valid, input logic [1:0] last);
    logic [1:0] idx;
    logic       found;
    rr_grant_f = last;
    found      = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && valid[idx]) begin
        rr_grant_f = idx;
        found      = 1'b1;
      end
    end
  endfunction

`ifdef MUX4_TOGGLE_CNT_EN
  function automatic logic [15:0] popcount_f(input logic [DW-1:0] word);
    popcount_f = 16'd0;
    for (int b = 0; b < DW; b++) begin
      popcount_f = popcount_f + {15'd0, word[b]};
    end
  endfunction
`endif

  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q,  out_data_d;
  logic [1:0]    out_sel_q,   out_sel_d;
  logic [1:0]    last_q,      last_d;

  logic          load_en_s;
  logic          any_valid_s;
  logic          xfer_s;
  logic [1:0]    grant_s;
  logic [DW-1:0] grant_data_s;

  assign load_en_s   = !out_valid_q || out_ready;
  assign any_valid_s = |in_valid;
  assign xfer_s      = load_en_s && any_valid_s;
  assign grant_s     = rr_grant_f(in_valid, last_q);

  // Lane data selected by the current grant.
  always_comb begin
    grant_data_s = in_data0;
    case (grant_s)
      2'd0:    grant_data_s = in_data0;
      2'd1:    grant_data_s = in_data1;
      2'd2:    grant_data_s = in_data2;
      2'd3:    grant_data_s = in_data3;
      default: grant_data_s = in_data0;
    endcase
  end

  // One-hot ready to the granted lane only when the buffer can take a word.
  always_comb begin
    in_ready = 4'b0000;
    if (xfer_s) begin
      in_ready[grant_s] = 1'b1;
    end else begin
      in_ready = 4'b0000;
    end
  end

  // Next state of the output buffer and arbitration pointer.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    last_d      = last_q;
    if (xfer_s) begin
      out_valid_d = 1'b1;
      out_data_d  = grant_data_s;
      out_sel_d   = grant_s;
      last_d      = grant_s;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Output buffer and pointer registers; reset puts lane 0 first in line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= 2'd0;
      last_q      <= 2'd3;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      last_q      <= last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

`ifdef MUX4_TOGGLE_CNT_EN
  logic [15:0] toggle_q, toggle_d;
  logic [16:0] toggle_sum_s;

  // Flips between consecutive loaded words, saturating at all-ones.
  always_comb begin
    toggle_sum_s = {1'b0, toggle_q} + {1'b0, popcount_f(grant_data_s ^ out_data_q)};
    toggle_d     = toggle_q;
    if (xfer_s) begin
      if (toggle_sum_s[16]) begin
        toggle_d = 16'hFFFF;
      end else begin
        toggle_d = toggle_sum_s[15:0];
      end
    end else begin
      toggle_d = toggle_q;
    end
  end

  // Toggle counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      toggle_q <= 16'd0;
    end else begin
      toggle_q <= toggle_d;
    end
  end

  assign toggle_cnt = toggle_q;
`endif

endmodule

// File: tb/tb_mux4x1_collector.sv
// Self-checking bench for mux4x1_collector: vector table plus scoreboard model.
module tb_mux4x1_collector;

  localparam int DW = 4;

  logic          clk;
  logic          rst_n;
  logic [3:0]    in_valid;
  logic [DW-1:0] in_data0, in_data1, in_data2, in_data3;
  logic [3:0]    in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    out_sel;
  logic          out_ready;
`ifdef MUX4_TOGGLE_CNT_EN
  logic [15:0]   toggle_cnt;
`endif

  mux4x1_collector #(.DW(DW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_data0(in_data0),
    .in_data1(in_data1),
    .in_data2(in_data2),
    .in_data3(in_data3),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_sel(out_sel),
    .out_ready(out_ready)
`ifdef MUX4_TOGGLE_CNT_EN
    ,
    .toggle_cnt(toggle_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  v;
    logic [15:0] d;
    logic        rdy;
    logic [3:0]  er;
    logic        eov;
    logic [3:0]  eod;
    logic [1:0]  eos;
  } vec_t;

  typedef struct {
    logic [3:0] data;
    logic [1:0] sel;
  } word_t;

  int total = 0;
  int bad   = 0;

  word_t      sb_q[$];
  int         m_last;
  logic [3:0] m_hold_data;
  logic [1:0] m_hold_sel;
  int         m_tog;

  vec_t tbl[21];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] v, input logic [15:0] d, input logic rdy,
                              input logic [3:0] er, input logic eov, input logic [3:0] eod,
                              input logic [1:0] eos);
    vec_t t;
    t.v = v; t.d = d; t.rdy = rdy; t.er = er; t.eov = eov; t.eod = eod; t.eos = eos;
    return t;
  endfunction

  task automatic model_reset();
    sb_q.delete();
    m_last      = 3;
    m_hold_data = 4'd0;
    m_hold_sel  = 2'd0;
    m_tog       = 0;
  endtask

  // Drive one cycle (entered just after a rising edge), check ready, then outputs.
  task automatic apply(input logic [3:0] v, input logic [15:0] d, input logic rdy,
                       input logic [3:0] er, input bit use_er);
    bit         mv, load, xfer;
    int         g, idx;
    logic [3:0] exp_rdy, gdata;
    word_t      w;
    in_valid = v;
    in_data0 = d[3:0];
    in_data1 = d[7:4];
    in_data2 = d[11:8];
    in_data3 = d[15:12];
    out_ready = rdy;
    #2;
    mv   = (sb_q.size() != 0);
    load = !mv || rdy;
    g    = -1;
    for (int k = 1; k <= 4; k++) begin
      idx = (m_last + k) % 4;
      if (g < 0 && v[idx]) g = idx;
    end
    xfer    = load && (v != 4'd0);
    exp_rdy = 4'd0;
    if (xfer) exp_rdy[g] = 1'b1;
    chk("in_ready_model", {28'd0, in_ready}, {28'd0, exp_rdy});
    if (use_er) chk("in_ready_table", {28'd0, in_ready}, {28'd0, er});
    @(posedge clk);
    if (mv && rdy) void'(sb_q.pop_front());
    if (xfer) begin
      gdata  = d[g*4 +: 4];
      w.data = gdata;
      w.sel  = 2'(g);
      sb_q.push_back(w);
      m_tog = m_tog + $countones(gdata ^ m_hold_data);
      if (m_tog > 65535) m_tog = 65535;
      m_hold_data = gdata;
      m_hold_sel  = 2'(g);
      m_last      = g;
    end
    #1;
    chk("out_valid", {31'd0, out_valid}, {31'd0, sb_q.size() != 0});
    if (sb_q.size() != 0) begin
      chk("out_data", {28'd0, out_data}, {28'd0, sb_q[0].data});
      chk("out_sel", {30'd0, out_sel}, {30'd0, sb_q[0].sel});
    end else begin
      chk("out_data_hold", {28'd0, out_data}, {28'd0, m_hold_data});
      chk("out_sel_hold", {30'd0, out_sel}, {30'd0, m_hold_sel});
    end
`ifdef MUX4_TOGGLE_CNT_EN
    chk("toggle_cnt_model", {16'd0, toggle_cnt}, m_tog);
`endif
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 4'd0;
    in_data0  = 4'd0;
    in_data1  = 4'd0;
    in_data2  = 4'd0;
    in_data3  = 4'd0;
    out_ready = 1'b0;
    model_reset();

    // Round-robin from reset, drain, single lane, backpressure, drain, empty load.
    for (int i = 0; i < 8; i++) begin
      tbl[i] = mk(4'hF, 16'h4321, 1'b1, 4'(1 << (i % 4)), 1'b1, 4'((i % 4) + 1), 2'(i % 4));
    end
    tbl[8]  = mk(4'h0, 16'h4321, 1'b1, 4'h0, 1'b0, 4'h4, 2'd3);
    tbl[9]  = mk(4'h4, 16'h0500, 1'b1, 4'h4, 1'b1, 4'h5, 2'd2);
    tbl[10] = mk(4'h1, 16'h0007, 1'b1, 4'h1, 1'b1, 4'h7, 2'd0);
    tbl[11] = mk(4'h3, 16'h00BA, 1'b0, 4'h0, 1'b1, 4'h7, 2'd0);
    tbl[12] = mk(4'h3, 16'h00BA, 1'b0, 4'h0, 1'b1, 4'h7, 2'd0);
    tbl[13] = mk(4'h3, 16'h00BA, 1'b0, 4'h0, 1'b1, 4'h7, 2'd0);
    tbl[14] = mk(4'h3, 16'h00BA, 1'b1, 4'h2, 1'b1, 4'hB, 2'd1);
    tbl[15] = mk(4'h3, 16'h00BA, 1'b1, 4'h1, 1'b1, 4'hA, 2'd0);
    tbl[16] = mk(4'h0, 16'h0000, 1'b1, 4'h0, 1'b0, 4'hA, 2'd0);
    tbl[17] = mk(4'h0, 16'h0000, 1'b0, 4'h0, 1'b0, 4'hA, 2'd0);
    tbl[18] = mk(4'h8, 16'hD000, 1'b0, 4'h8, 1'b1, 4'hD, 2'd3);
    tbl[19] = mk(4'h8, 16'hD000, 1'b0, 4'h0, 1'b1, 4'hD, 2'd3);
    tbl[20] = mk(4'h0, 16'h0000, 1'b1, 4'h0, 1'b0, 4'hD, 2'd3);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_out_data", {28'd0, out_data}, 32'd0);
    chk("reset_out_sel", {30'd0, out_sel}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 21; i++) begin
      apply(tbl[i].v, tbl[i].d, tbl[i].rdy, tbl[i].er, 1'b1);
      chk($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].eov});
      chk($sformatf("vec%0d_out_data", i), {28'd0, out_data}, {28'd0, tbl[i].eod});
      chk($sformatf("vec%0d_out_sel", i), {30'd0, out_sel}, {30'd0, tbl[i].eos});
    end

    // Asynchronous reset with a word buffered, away from any clock edge.
    apply(4'h2, 16'h0090, 1'b0, 4'h0, 1'b0);
    chk("pre_reset_full", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_out_data", {28'd0, out_data}, 32'd0);
    chk("async_rst_out_sel", {30'd0, out_sel}, 32'd0);
`ifdef MUX4_TOGGLE_CNT_EN
    chk("async_rst_toggle", {16'd0, toggle_cnt}, 32'd0);
`endif
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // First grant after reset goes to lane 0; lane 0 carries 0000.
    apply(4'hF, 16'h4320, 1'b1, 4'h1, 1'b1);
    chk("post_reset_sel", {30'd0, out_sel}, 32'd0);
    apply(4'h1, 16'h000D, 1'b1, 4'h1, 1'b1);
`ifdef MUX4_TOGGLE_CNT_EN
    chk("toggle_after_1101", {16'd0, toggle_cnt}, 32'd3);
`endif
    apply(4'h1, 16'h0008, 1'b1, 4'h1, 1'b1);
`ifdef MUX4_TOGGLE_CNT_EN
    chk("toggle_after_1000", {16'd0, toggle_cnt}, 32'd5);
    for (int i = 0; i < 16400; i++) begin
      in_valid  = 4'h1;
      in_data0  = (i % 2 == 0) ? 4'hF : 4'h0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
    end
    chk("toggle_saturated", {16'd0, toggle_cnt}, 32'h0000FFFF);
    in_data0 = ~in_data0;
    @(posedge clk);
    #1;
    chk("toggle_sat_holds", {16'd0, toggle_cnt}, 32'h0000FFFF);
`endif
    apply(4'h0, 16'h0000, 1'b1, 4'h0, 1'b1);
    chk("final_drain", {31'd0, out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
